rst_seq_ctrl: RTL and testbench
===============================

Name: rst_seq_ctrl

Overview:
- Reset sequencer for the UART subsystem.
- Holds N downstream blocks in reset, then releases them one at a time in a fixed order: stage 0 first (e.g. clock/PLL), then baud generator, then uart_rx/uart_tx.
- Each release waits for that stage's ready handshake.
- Handles soft-reset requests, ready timeouts and ready loss, with a bounded retry count.

Parameters:
- N_STAGE, 3, number of sequenced reset outputs (1..8).
- HOLD_CYC, 16, cycles all stage resets stay asserted before stage 0 is released (>=1).
- GAP_CYC, 8, cycles between a stage reporting ready and the next stage's release (>=1).
- TIMEOUT_CYC, 1000, maximum cycles to wait for stage_ready[i] after its release (>=2).
- RETRY_MAX, 3, full-sequence restarts allowed after faults before latching a fatal error (0..15).

Ports:
- sys_clk  in  1  single system clock.
- sys_rst  in  1  synchronous, active-high master reset.
- soft_rst_req  in  1  single-cycle request to rerun the whole sequence.
- stage_ready  in  N_STAGE  per-stage ready/locked indication; level, synchronous to sys_clk.
- stage_rst  out  N_STAGE  per-stage reset; active-high; bit i drives stage i.
- seq_done  out  1  high while all stages are released and ready.
- seq_busy  out  1  high while the sequence is in progress (HOLD/REL/WAIT/GAP).
- fault  out  1  one-cycle pulse on each timeout or ready-loss event.
- fault_stage  out  3  index of the stage that caused the last fault; held until the next fault.
- fatal  out  1  sticky; set when the retry count is exhausted.

Behaviour:
- Reset (sys_rst=1 at a clock edge), on the next cycle:
  - stage_rst = all ones; seq_done=0; seq_busy=1; fault=0; fault_stage=0; fatal=0.
  - Retry counter = 0; state = HOLD; counter = 0.
- One shared down/up counter, width clog2(max(HOLD_CYC,GAP_CYC,TIMEOUT_CYC)+1). One stage index register, width clog2(N_STAGE) (min 1).
- HOLD:
  - All stage_rst bits = 1.
  - Count HOLD_CYC cycles; then idx=0 and go to REL.
- REL (1 cycle): clear stage_rst[idx]; counter=0; go to WAIT.
- WAIT:
  - If stage_ready[idx]=1: go to GAP if idx<N_STAGE-1, else go to DONE.
  - Else if counter reaches TIMEOUT_CYC-1: go to FAULT.
  - Ready is sampled starting the cycle after stage_rst[idx] falls. A ready that is already high then is accepted: WAIT lasts 1 cycle.
- GAP: count GAP_CYC cycles; then idx=idx+1 and go to REL.
- DONE: seq_done=1; seq_busy=0; all stage_rst bits = 0.
- Ready monitoring: in WAIT/GAP/DONE, if any already-released stage (index < current idx, or any stage in DONE) has stage_ready=0, go to FAULT. The stage that drops is reported. If several drop at once, report the lowest index.
- FAULT (1 cycle):
  - fault=1; fault_stage=offending idx; stage_rst = all ones.
  - If retry count < RETRY_MAX: increment it and go to HOLD.
  - Else: set fatal=1 and go to DEAD.
- DEAD: all stage_rst bits = 1; seq_busy=0; seq_done=0. Only sys_rst leaves DEAD; soft_rst_req is ignored.
- soft_rst_req=1 in any state except DEAD:
  - Next cycle: state = HOLD, stage_rst = all ones, counter = 0, seq_done=0.
  - Retry count is cleared, but fatal is unaffected.
  - Takes priority over a same-cycle ready, timeout or fault condition; fault is not pulsed.
- sys_rst has priority over everything, and applies mid-sequence exactly as at power-up.
- stage_rst bits are released strictly in ascending order and are never released out of order. Bit i is deasserted only from REL with idx=i.
- All outputs are registered; no combinational path from input to output.
- Latency from reset release to seq_done, with every ready already high: HOLD_CYC + N_STAGE*(1 REL + 1 WAIT) + (N_STAGE-1)*GAP_CYC + 1 cycles.

Decomposition:
- Package uart_sys_pkg holds:
  - state enum: HOLD, REL, WAIT, GAP, DONE, FAULT, DEAD;
  - the clog2-based width constants;
  - the fault code constants (TIMEOUT, READY_LOST).
- No sub-module. The FSM, shared counter and retry counter form a single module.

Test Plan:
- Defaults, stage_ready tied to 3'b111 → stage_rst goes 111→110→100→000 at cycles 17, 27, 37 after reset release. seq_done asserts at cycle 38 (latency 16+6+16+1=39 counts from cycle 0).
- stage_ready[1] held at 0 → after 1000 WAIT cycles: fault pulses, fault_stage=1, stage_rst=111. Sequence retries 3 times, then fatal=1 and stage_rst remains 111 indefinitely.
- After seq_done, drop stage_ready[0] for 1 cycle → next cycle fault=1, fault_stage=0, stage_rst=111. Sequence restarts and completes once ready returns.
- soft_rst_req pulsed during GAP after stage 0 → stage_rst=111 next cycle, fault stays 0. Full sequence re-runs; retry count is cleared (verify that a later fault still gets 3 retries).
- sys_rst asserted in WAIT for stage 2 → all outputs reach their reset values next cycle, including fatal=0 when coming from DEAD.
- soft_rst_req in the same cycle that WAIT times out → no fault pulse, state goes to HOLD, retry count = 0.

Source files
------------

// File: rtl/uart_sys_pkg.sv
// Shared types and sizing helpers for the UART subsystem reset sequencer.
// Widths derive from the instantiating module's timing parameters.
package uart_sys_pkg;

  typedef enum logic [2:0] {
    HOLD,
    REL,
    WAIT,
    GAP,
    DONE,
    FAULT,
    DEAD
  } state_e;

  typedef enum logic [1:0] {
    FLT_NONE,
    TIMEOUT,
    READY_LOST
  } fault_code_e;

  localparam int unsigned STAGE_MAX     = 8;
  localparam int unsigned FAULT_STAGE_W = 3;
  localparam int unsigned RETRY_W       = 4;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter must hold the largest of the three terminal counts.
  function automatic int unsigned cnt_width(input int unsigned hold_cyc,
                                            input int unsigned gap_cyc,
                                            input int unsigned timeout_cyc);
    return $clog2(max3(hold_cyc, gap_cyc, timeout_cyc) + 1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned n_stage);
    return (n_stage > 1) ? $clog2(n_stage) : 1;
  endfunction

  localparam int unsigned CNT_W_DEFAULT = cnt_width(16, 8, 1000);
  localparam int unsigned IDX_W_DEFAULT = idx_width(3);

endpackage

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all stages in reset, releases them in ascending order
// gated by per-stage ready, with timeout/ready-loss fault handling and retries.
module rst_seq_ctrl
  import uart_sys_pkg::*;
#(
  parameter int unsigned N_STAGE     = 3,
  parameter int unsigned HOLD_CYC    = 16,
  parameter int unsigned GAP_CYC     = 8,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned RETRY_MAX   = 3
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     soft_rst_req,
  input  logic [N_STAGE-1:0]       stage_ready,
  output logic [N_STAGE-1:0]       stage_rst,
  output logic                     seq_done,
  output logic                     seq_busy,
  output logic                     fault,
  output logic [FAULT_STAGE_W-1:0] fault_stage,
  output logic                     fatal
);

  localparam int unsigned CNT_W = cnt_width(HOLD_CYC, GAP_CYC, TIMEOUT_CYC);
  localparam int unsigned IDX_W = idx_width(N_STAGE);

  state_e                   state;
  logic [CNT_W-1:0]         cnt;
  logic [IDX_W-1:0]         idx;
  logic [RETRY_W-1:0]       retry;

  logic [N_STAGE-1:0]       released;
  logic [N_STAGE-1:0]       lost;
  logic [FAULT_STAGE_W-1:0] lost_idx;
  logic                     lost_found;
  fault_code_e              fcode;
  logic [FAULT_STAGE_W-1:0] fcode_stage;

  // Stages already released: everything in DONE, otherwise those below idx.
  always_comb begin
    released = '0;
    for (int unsigned i = 0; i < N_STAGE; i++) begin
      if (state == DONE || i < 32'(idx)) released[i] = 1'b1;
    end
  end

  assign lost = released & ~stage_ready;

  always_comb begin
    lost_idx   = '0;
    lost_found = 1'b0;
    for (int unsigned i = 0; i < N_STAGE; i++) begin
      if (lost[i] && !lost_found) begin
        lost_idx   = FAULT_STAGE_W'(i);
        lost_found = 1'b1;
      end
    end
  end

  // Ready loss outranks timeout; the stage under test is not yet "released".
  always_comb begin
    fcode       = FLT_NONE;
    fcode_stage = '0;
    if ((state == WAIT || state == GAP || state == DONE) && lost_found) begin
      fcode       = READY_LOST;
      fcode_stage = lost_idx;
    end else if (state == WAIT && !stage_ready[idx] &&
                 cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
      fcode       = TIMEOUT;
      fcode_stage = FAULT_STAGE_W'(idx);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= HOLD;
      cnt         <= '0;
      idx         <= '0;
      retry       <= '0;
      stage_rst   <= '1;
      seq_done    <= 1'b0;
      seq_busy    <= 1'b1;
      fault       <= 1'b0;
      fault_stage <= '0;
      fatal       <= 1'b0;
    end else if (soft_rst_req && state != DEAD) begin
      state     <= HOLD;
      cnt       <= '0;
      idx       <= '0;
      retry     <= '0;
      stage_rst <= '1;
      seq_done  <= 1'b0;
      seq_busy  <= 1'b1;
      fault     <= 1'b0;
    end else if (fcode != FLT_NONE) begin
      state       <= FAULT;
      cnt         <= '0;
      stage_rst   <= '1;
      seq_done    <= 1'b0;
      seq_busy    <= 1'b0;
      fault       <= 1'b1;
      fault_stage <= fcode_stage;
    end else begin
      fault <= 1'b0;
      case (state)
        HOLD: begin
          stage_rst <= '1;
          if (cnt == CNT_W'(HOLD_CYC - 1)) begin
            cnt   <= '0;
            idx   <= '0;
            state <= REL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REL: begin
          stage_rst[idx] <= 1'b0;
          cnt            <= '0;
          state          <= WAIT;
        end
        WAIT: begin
          if (stage_ready[idx]) begin
            cnt <= '0;
            if (idx < IDX_W'(N_STAGE - 1)) begin
              state <= GAP;
            end else begin
              state     <= DONE;
              stage_rst <= '0;
              seq_done  <= 1'b1;
              seq_busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == CNT_W'(GAP_CYC - 1)) begin
            cnt   <= '0;
            idx   <= idx + 1'b1;
            state <= REL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          stage_rst <= '0;
        end
        FAULT: begin
          stage_rst <= '1;
          cnt       <= '0;
          idx       <= '0;
          if (retry < RETRY_W'(RETRY_MAX)) begin
            retry    <= retry + 1'b1;
            seq_busy <= 1'b1;
            state    <= HOLD;
          end else begin
            fatal    <= 1'b1;
            seq_busy <= 1'b0;
            state    <= DEAD;
          end
        end
        DEAD: begin
          stage_rst <= '1;
          seq_busy  <= 1'b0;
          seq_done  <= 1'b0;
        end
        default: begin
          state     <= HOLD;
          cnt       <= '0;
          stage_rst <= '1;
          seq_busy  <= 1'b1;
          seq_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scenario bench for rst_seq_ctrl: each task schedules expected output values
// by cycle into a queue and compares them as the sequence runs.
module tb_rst_seq_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       soft_rst_req = 1'b0;
  logic [2:0] stage_ready = 3'b000;
  logic [2:0] stage_rst;
  logic       seq_done;
  logic       seq_busy;
  logic       fault;
  logic [2:0] fault_stage;
  logic       fatal;

  int n_total = 0;
  int n_bad   = 0;

  localparam int S_RST = 0, S_DONE = 1, S_BUSY = 2, S_FAULT = 3, S_FSTG = 4, S_FATAL = 5;

  typedef struct {
    int         at;
    int         sig;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];

  rst_seq_ctrl #(
    .N_STAGE    (3),
    .HOLD_CYC   (16),
    .GAP_CYC    (8),
    .TIMEOUT_CYC(1000),
    .RETRY_MAX  (3)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .soft_rst_req(soft_rst_req),
    .stage_ready (stage_ready),
    .stage_rst   (stage_rst),
    .seq_done    (seq_done),
    .seq_busy    (seq_busy),
    .fault       (fault),
    .fault_stage (fault_stage),
    .fatal       (fatal)
  );

  always #5 sys_clk = ~sys_clk;

  // Keep the queue ordered by cycle so the head is always the next due entry.
  function automatic void sb_push(input int at, input int sig, input logic [7:0] val);
    exp_t e;
    int   pos;
    e.at  = at;
    e.sig = sig;
    e.val = val;
    pos   = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].at > at) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, e);
  endfunction

  function automatic logic [7:0] observe(input int sig);
    case (sig)
      S_RST:   return {5'b0, stage_rst};
      S_DONE:  return {7'b0, seq_done};
      S_BUSY:  return {7'b0, seq_busy};
      S_FAULT: return {7'b0, fault};
      S_FSTG:  return {5'b0, fault_stage};
      default: return {7'b0, fatal};
    endcase
  endfunction

  function automatic string sig_name(input int sig);
    case (sig)
      S_RST:   return "stage_rst";
      S_DONE:  return "seq_done";
      S_BUSY:  return "seq_busy";
      S_FAULT: return "fault";
      S_FSTG:  return "fault_stage";
      default: return "fatal";
    endcase
  endfunction

  // Reset edge happens between the two negedges; return at cycle 0.
  task automatic start(input logic [2:0] rdy);
    @(negedge sys_clk);
    sys_rst      = 1'b1;
    soft_rst_req = 1'b0;
    stage_ready  = rdy;
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic test_reset;
    exp_t e;
    logic [7:0] obs;
    start(3'b111);
    sb_push(0, S_RST, 8'h7);
    sb_push(0, S_DONE, 8'h0);
    sb_push(0, S_BUSY, 8'h1);
    sb_push(0, S_FAULT, 8'h0);
    sb_push(0, S_FSTG, 8'h0);
    sb_push(0, S_FATAL, 8'h0);
    sb_push(15, S_RST, 8'h7);
    for (int c = 0; sb.size() > 0 && c < 20000; c++) begin
      if (c > 0) @(negedge sys_clk);
      while (sb.size() > 0 && sb[0].at == c) begin
        e = sb.pop_front();
        obs = observe(e.sig);
        n_total++;
        if (obs !== e.val) begin
          n_bad++;
          $display("FAIL reset.%s c=%0d got=%0h want=%0h", sig_name(e.sig), c, obs, e.val);
        end
      end
    end
  endtask

  task automatic test_sequence;
    exp_t e;
    logic [7:0] obs;
    start(3'b111);
    sb_push(16, S_RST, 8'h7);
    sb_push(17, S_RST, 8'h6);
    sb_push(26, S_RST, 8'h6);
    sb_push(27, S_RST, 8'h4);
    sb_push(36, S_RST, 8'h4);
    sb_push(37, S_RST, 8'h0);
    sb_push(37, S_DONE, 8'h0);
    sb_push(37, S_BUSY, 8'h1);
    sb_push(38, S_DONE, 8'h1);
    sb_push(38, S_BUSY, 8'h0);
    sb_push(38, S_FAULT, 8'h0);
    sb_push(60, S_DONE, 8'h1);
    sb_push(60, S_RST, 8'h0);
    for (int c = 0; sb.size() > 0 && c < 20000; c++) begin
      if (c > 0) @(negedge sys_clk);
      while (sb.size() > 0 && sb[0].at == c) begin
        e = sb.pop_front();
        obs = observe(e.sig);
        n_total++;
        if (obs !== e.val) begin
          n_bad++;
          $display("FAIL seq.%s c=%0d got=%0h want=%0h", sig_name(e.sig), c, obs, e.val);
        end
      end
    end
  endtask

  task automatic test_ready_loss;
    exp_t e;
    logic [7:0] obs;
    start(3'b111);
    sb_push(50, S_FAULT, 8'h0);
    sb_push(51, S_FAULT, 8'h1);
    sb_push(51, S_FSTG, 8'h0);
    sb_push(51, S_RST, 8'h7);
    sb_push(51, S_DONE, 8'h0);
    sb_push(52, S_FAULT, 8'h0);
    sb_push(52, S_BUSY, 8'h1);
    sb_push(69, S_RST, 8'h6);
    sb_push(89, S_RST, 8'h0);
    sb_push(89, S_DONE, 8'h0);
    sb_push(90, S_DONE, 8'h1);
    sb_push(101, S_FAULT, 8'h1);
    sb_push(101, S_FSTG, 8'h1);
    sb_push(102, S_FAULT, 8'h0);
    sb_push(102, S_FSTG, 8'h1);
    sb_push(140, S_DONE, 8'h1);
    for (int c = 0; sb.size() > 0 && c < 20000; c++) begin
      if (c > 0) @(negedge sys_clk);
      while (sb.size() > 0 && sb[0].at == c) begin
        e = sb.pop_front();
        obs = observe(e.sig);
        n_total++;
        if (obs !== e.val) begin
          n_bad++;
          $display("FAIL loss.%s c=%0d got=%0h want=%0h", sig_name(e.sig), c, obs, e.val);
        end
      end
      if (c == 50) stage_ready = 3'b110;
      if (c == 51) stage_ready = 3'b111;
      if (c == 100) stage_ready = 3'b001;
      if (c == 101) stage_ready = 3'b111;
    end
  endtask

  task automatic test_sys_rst_midseq;
    exp_t e;
    logic [7:0] obs;
    start(3'b011);
    sb_push(37, S_RST, 8'h0);
    sb_push(50, S_BUSY, 8'h1);
    sb_push(51, S_RST, 8'h7);
    sb_push(51, S_BUSY, 8'h1);
    sb_push(51, S_DONE, 8'h0);
    sb_push(51, S_FAULT, 8'h0);
    sb_push(51, S_FATAL, 8'h0);
    sb_push(67, S_RST, 8'h7);
    sb_push(68, S_RST, 8'h6);
    for (int c = 0; sb.size() > 0 && c < 20000; c++) begin
      if (c > 0) @(negedge sys_clk);
      while (sb.size() > 0 && sb[0].at == c) begin
        e = sb.pop_front();
        obs = observe(e.sig);
        n_total++;
        if (obs !== e.val) begin
          n_bad++;
          $display("FAIL sysrst.%s c=%0d got=%0h want=%0h", sig_name(e.sig), c, obs, e.val);
        end
      end
      if (c == 50) sys_rst = 1'b1;
      if (c == 51) sys_rst = 1'b0;
    end
  endtask

  // Stage 1 never ready: four timeouts 1028 cycles apart, then DEAD.
  task automatic test_timeout;
    exp_t e;
    logic [7:0] obs;
    int f;
    start(3'b101);
    sb_push(27, S_RST, 8'h4);
    sb_push(1026, S_RST, 8'h4);
    sb_push(1026, S_FAULT, 8'h0);
    for (int k = 0; k < 4; k++) begin
      f = 1027 + 1028 * k;
      sb_push(f, S_FAULT, 8'h1);
      sb_push(f, S_FSTG, 8'h1);
      sb_push(f, S_RST, 8'h7);
      sb_push(f, S_FATAL, 8'h0);
      sb_push(f + 1, S_FAULT, 8'h0);
      sb_push(f + 1, S_BUSY, (k < 3) ? 8'h1 : 8'h0);
    end
    sb_push(4112, S_FATAL, 8'h1);
    sb_push(4202, S_RST, 8'h7);
    sb_push(4202, S_BUSY, 8'h0);
    sb_push(4202, S_FAULT, 8'h0);
    sb_push(4300, S_FATAL, 8'h1);
    sb_push(4300, S_DONE, 8'h0);
    sb_push(4300, S_FSTG, 8'h1);
    for (int c = 0; sb.size() > 0 && c < 20000; c++) begin
      if (c > 0) @(negedge sys_clk);
      while (sb.size() > 0 && sb[0].at == c) begin
        e = sb.pop_front();
        obs = observe(e.sig);
        n_total++;
        if (obs !== e.val) begin
          n_bad++;
          $display("FAIL tmo.%s c=%0d got=%0h want=%0h", sig_name(e.sig), c, obs, e.val);
        end
      end
      if (c == 4200) soft_rst_req = 1'b1;
      if (c == 4201) soft_rst_req = 1'b0;
    end
  endtask

  // Entered while DEAD; sys_rst must clear the sticky fatal and fault_stage.
  task automatic test_dead_reset;
    exp_t e;
    logic [7:0] obs;
    sb_push(0, S_FATAL, 8'h1);
    sb_push(1, S_FATAL, 8'h0);
    sb_push(1, S_FSTG, 8'h0);
    sb_push(1, S_RST, 8'h7);
    sb_push(1, S_BUSY, 8'h1);
    sb_push(1, S_DONE, 8'h0);
    sb_push(18, S_RST, 8'h6);
    for (int c = 0; sb.size() > 0 && c < 20000; c++) begin
      if (c > 0) @(negedge sys_clk);
      while (sb.size() > 0 && sb[0].at == c) begin
        e = sb.pop_front();
        obs = observe(e.sig);
        n_total++;
        if (obs !== e.val) begin
          n_bad++;
          $display("FAIL dead.%s c=%0d got=%0h want=%0h", sig_name(e.sig), c, obs, e.val);
        end
      end
      if (c == 0) begin
        sys_rst     = 1'b1;
        stage_ready = 3'b111;
      end
      if (c == 1) sys_rst = 1'b0;
    end
  endtask

  // One fault bumps the retry count; soft reset in GAP must clear it again.
  task automatic test_soft_rst;
    exp_t e;
    logic [7:0] obs;
    int f;
    start(3'b111);
    sb_push(38, S_DONE, 8'h1);
    sb_push(41, S_FAULT, 8'h1);
    sb_push(41, S_FSTG, 8'h0);
    sb_push(59, S_RST, 8'h6);
    sb_push(62, S_RST, 8'h6);
    sb_push(63, S_RST, 8'h7);
    sb_push(63, S_FAULT, 8'h0);
    sb_push(63, S_BUSY, 8'h1);
    sb_push(63, S_DONE, 8'h0);
    sb_push(64, S_FAULT, 8'h0);
    sb_push(80, S_RST, 8'h6);
    for (int k = 0; k < 4; k++) begin
      f = 1090 + 1028 * k;
      sb_push(f, S_FAULT, 8'h1);
      sb_push(f, S_FSTG, 8'h1);
    end
    sb_push(3147, S_FATAL, 8'h0);
    sb_push(4174, S_FATAL, 8'h0);
    sb_push(4175, S_FATAL, 8'h1);
    for (int c = 0; sb.size() > 0 && c < 20000; c++) begin
      if (c > 0) @(negedge sys_clk);
      while (sb.size() > 0 && sb[0].at == c) begin
        e = sb.pop_front();
        obs = observe(e.sig);
        n_total++;
        if (obs !== e.val) begin
          n_bad++;
          $display("FAIL soft.%s c=%0d got=%0h want=%0h", sig_name(e.sig), c, obs, e.val);
        end
      end
      if (c == 40) stage_ready = 3'b110;
      if (c == 41) stage_ready = 3'b111;
      if (c == 62) soft_rst_req = 1'b1;
      if (c == 63) begin
        soft_rst_req = 1'b0;
        stage_ready  = 3'b101;
      end
    end
  endtask

  // Soft reset lands on the timeout edge: no fault, and all retries remain.
  task automatic test_soft_timeout;
    exp_t e;
    logic [7:0] obs;
    int f;
    start(3'b101);
    sb_push(1026, S_RST, 8'h4);
    sb_push(1026, S_FAULT, 8'h0);
    sb_push(1027, S_FAULT, 8'h0);
    sb_push(1027, S_RST, 8'h7);
    sb_push(1027, S_BUSY, 8'h1);
    sb_push(1028, S_FAULT, 8'h0);
    for (int k = 0; k < 4; k++) begin
      f = 2054 + 1028 * k;
      sb_push(f, S_FAULT, 8'h1);
      sb_push(f, S_FATAL, 8'h0);
    end
    sb_push(4111, S_FATAL, 8'h0);
    sb_push(5139, S_FATAL, 8'h1);
    sb_push(5139, S_RST, 8'h7);
    for (int c = 0; sb.size() > 0 && c < 20000; c++) begin
      if (c > 0) @(negedge sys_clk);
      while (sb.size() > 0 && sb[0].at == c) begin
        e = sb.pop_front();
        obs = observe(e.sig);
        n_total++;
        if (obs !== e.val) begin
          n_bad++;
          $display("FAIL softtmo.%s c=%0d got=%0h want=%0h", sig_name(e.sig), c, obs, e.val);
        end
      end
      if (c == 1026) soft_rst_req = 1'b1;
      if (c == 1027) soft_rst_req = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_ready_loss();
    test_sys_rst_midseq();
    test_timeout();
    test_dead_reset();
    test_soft_rst();
    test_soft_timeout();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
